// File: rtl/mipi_port_mux.sv
// Purpose: routes one MIPI master (SCLK/SDA) to one of NCH board ports, with glitch-free bank switching.
// Latency: pad outputs are registered (1 cycle); sdi_out lags sda_i by SYNC_STAGES cycles; switch ack GUARD_CYC+1 after drain.
// Backpressure: busy holds a pending switch in DRAIN indefinitely; requests arriving while switching are dropped silently.
module mipi_port_mux #(
    parameter int NCH         = 4,
    parameter int BANK_NBIT   = 2,
    parameter int GUARD_CYC   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bank_req_vd,
    input  logic [BANK_NBIT-1:0] bank_req,
    input  logic                 busy,
    output logic                 bank_ack,
    output logic                 bank_err,
    output logic                 switching,
    output logic [BANK_NBIT-1:0] cur_bank,
    input  logic                 sclk_in,
    input  logic                 sdo_in,
    input  logic                 sdo_en_in,
    output logic                 sdi_out,
    output logic [NCH-1:0]       sclk_o,
    output logic [NCH-1:0]       sda_o,
    output logic [NCH-1:0]       sda_oe,
    input  logic [NCH-1:0]       sda_i
);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_PARK   = 2'd2;

    localparam int CNT_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [CNT_W-1:0]   GUARD_LOAD = CNT_W'(GUARD_CYC - 1);
    // One extra bit so the range check works even when 2**BANK_NBIT == NCH.
    localparam logic [BANK_NBIT:0] NCH_W      = (BANK_NBIT + 1)'(NCH);

    logic [1:0]           state_q, state_d;
    logic [BANK_NBIT-1:0] cur_bank_q, cur_bank_d;
    logic [BANK_NBIT-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [NCH-1:0]       sclk_q, sclk_d;
    logic [NCH-1:0]       sda_q, sda_d;
    logic [NCH-1:0]       oe_q, oe_d;
    logic [NCH-1:0]       sync_q [SYNC_STAGES];
    logic                 sdi_sel;

    // Bank-switch sequencing: ACTIVE -> DRAIN (wait for !busy) -> PARK (guard time) -> ACTIVE with new bank.
    always_comb begin
        state_d    = state_q;
        cur_bank_d = cur_bank_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (bank_req_vd) begin
                    if ({1'b0, bank_req} >= NCH_W) begin
                        err_d = 1'b1;
                    end else if (bank_req == cur_bank_q) begin
                        ack_d = 1'b1;
                    end else begin
                        pend_d  = bank_req;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!busy) begin
                    state_d = ST_PARK;
                    cnt_d   = GUARD_LOAD;
                end
            end
            ST_PARK: begin
                if (cnt_q == '0) begin
                    state_d    = ST_ACTIVE;
                    cur_bank_d = pend_q;
                    ack_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    // Pad values are derived from the next state so the new bank is routed on the same edge that acks.
    always_comb begin
        sclk_d = '0;
        sda_d  = '0;
        oe_d   = '1;
        if (state_d != ST_PARK) begin
            for (int p = 0; p < NCH; p++) begin
                if (cur_bank_d == (BANK_NBIT)'(p)) begin
                    sclk_d[p] = sclk_in;
                    sda_d[p]  = sdo_in;
                    oe_d[p]   = sdo_en_in;
                end
            end
        end
    end

    // Control state and registered pad outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACTIVE;
            cur_bank_q <= '0;
            pend_q     <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            sclk_q     <= '0;
            sda_q      <= '0;
            oe_q       <= '1;
        end else begin
            state_q    <= state_d;
            cur_bank_q <= cur_bank_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            sclk_q     <= sclk_d;
            sda_q      <= sda_d;
            oe_q       <= oe_d;
        end
    end

    // Every port's SDA input is synchronised, so switching banks never exposes a fresh async sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= sda_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Return path: pick the synchronised SDA of the current bank.
    always_comb begin
        sdi_sel = 1'b0;
        for (int p = 0; p < NCH; p++) begin
            if (cur_bank_q == (BANK_NBIT)'(p)) begin
                sdi_sel = sync_q[SYNC_STAGES-1][p];
            end
        end
    end

    assign sdi_out   = (state_q != ST_PARK) && sdi_sel;
    assign switching = (state_q != ST_ACTIVE);
    assign cur_bank  = cur_bank_q;
    assign bank_ack  = ack_q;
    assign bank_err  = err_q;
    assign sclk_o    = sclk_q;
    assign sda_o     = sda_q;
    assign sda_oe    = oe_q;

endmodule
